dm_arbiter: RTL

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// Two-requester (core/host) data-memory arbiter with 1-cycle read return and
// registered write data. Define DM_ARB_STARVE_EN to enable the host starvation override.
module dm_arbiter #(
   parameter int DMA_SIZE   = 3,
   parameter int DMD_SIZE   = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                core_req,
   input  logic                core_wrb,
   input  logic [DMA_SIZE-1:0] core_add,
   input  logic [DMD_SIZE-1:0] core_wdt,
   input  logic                host_req,
   input  logic                host_wrb,
   input  logic [DMA_SIZE-1:0] host_add,
   input  logic [DMD_SIZE-1:0] host_wdt,
   output logic                core_gnt,
   output logic                host_gnt,
   output logic                core_rvalid,
   output logic                host_rvalid,
   output logic [DMD_SIZE-1:0] rdata,
   output logic                ps_dm_cslt,
   output logic                ps_dm_wrb,
   output logic [DMA_SIZE-1:0] dg_dm_add,
   output logic [DMD_SIZE-1:0] bc_dt,
   input  logic [DMD_SIZE-1:0] dm_bc_dt
);

   typedef enum logic [2:0] {IDLE, CORE_RD, CORE_WR, HOST_RD, HOST_WR} owner_t;

   owner_t state, state_nx;
   logic   armed;
   logic   force_host;

   // Grants stay off until the first clock edge after reset release.
   always_ff @(posedge clk or negedge reset)
      if (!reset) armed <= 1'b0;
      else        armed <= 1'b1;

`ifdef DM_ARB_STARVE_EN
   localparam int CW = $clog2(STARVE_MAX + 1);
   logic [CW-1:0] starve_cnt;

   assign force_host = host_req && (starve_cnt == CW'(STARVE_MAX));

   always_ff @(posedge clk or negedge reset)
      if (!reset)                              starve_cnt <= '0;
      else if (!host_req || host_gnt)          starve_cnt <= '0;
      else if (starve_cnt != CW'(STARVE_MAX))  starve_cnt <= starve_cnt + 1'b1;
`else
   assign force_host = 1'b0;
`endif

   assign core_gnt = armed & core_req & ~force_host;
   assign host_gnt = armed & host_req & (~core_req | force_host);

   always_comb begin
      ps_dm_cslt = 1'b0;
      ps_dm_wrb  = 1'b0;
      dg_dm_add  = '0;
      if (core_gnt) begin
         ps_dm_cslt = 1'b1;
         ps_dm_wrb  = core_wrb;
         dg_dm_add  = core_add;
      end else if (host_gnt) begin
         ps_dm_cslt = 1'b1;
         ps_dm_wrb  = host_wrb;
         dg_dm_add  = host_add;
      end
   end

   // Memory commits the write one cycle after select, so data lags the grant.
   always_ff @(posedge clk or negedge reset)
      if (!reset)                    bc_dt <= '0;
      else if (core_gnt && core_wrb) bc_dt <= core_wdt;
      else if (host_gnt && host_wrb) bc_dt <= host_wdt;

   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= state_nx;

   always_comb begin
      state_nx = IDLE;
      if (core_gnt)      state_nx = core_wrb ? CORE_WR : CORE_RD;
      else if (host_gnt) state_nx = host_wrb ? HOST_WR : HOST_RD;
   end

   assign core_rvalid = (state == CORE_RD);
   assign host_rvalid = (state == HOST_RD);
   assign rdata       = (core_rvalid | host_rvalid) ? dm_bc_dt : '0;

endmodule
